esm_issue_scheduler: RTL and testbench

Issue-selection stage directly downstream of the ESM dependency-analysis core. It consumes the per-entry `independent_instr` bitmap and tracks the lifecycle of every instruction-buffer entry (free, waiting, issued). Each cycle it picks one ready entry by round-robin and presents it on a valid/ready issue port. It frees entries on completion, so the dependency tables and buffer slots can be reused.

---
 rtl/esm_issue_scheduler.sv | 120 ++++++++++++
 tb/tb_esm_issue_scheduler.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/esm_issue_scheduler.sv
// Issue-selection stage after the ESM dependency core: tracks entry lifecycle
// (FREE/WAITING/ISSUED) and issues one ready entry per cycle, round-robin.
module esm_issue_scheduler #(
    parameter int bs = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   alloc_valid,
    input  logic [$clog2(bs)-1:0]  alloc_index,
    input  logic [0:bs-1]          independent_instr,
    output logic                   issue_valid,
    output logic [$clog2(bs)-1:0]  issue_index,
    input  logic                   issue_ready,
    input  logic                   complete_valid,
    input  logic [$clog2(bs)-1:0]  complete_index,
    output logic [$clog2(bs):0]    occupancy,
    output logic                   full,
    output logic                   empty,
    output logic                   err
);
    localparam int IW = $clog2(bs);

    typedef enum logic [1:0] {FREE = 2'd0, WAITING = 2'd1, ISSUED = 2'd2} ent_t;

    ent_t          r_state [bs];
    ent_t          w_state_nxt [bs];
    logic          r_issue_valid;
    logic [IW-1:0] r_issue_index;
    logic [IW-1:0] r_rr_ptr;
    logic [IW:0]   r_occ;
    logic [IW:0]   w_occ_nxt;
    logic          r_err;
    logic          w_err_evt;
    logic          w_hs;
    logic [bs-1:0] w_cand;
    logic          w_found;
    logic [IW-1:0] w_pick;
    logic [IW-1:0] w_idx;

    assign w_hs = r_issue_valid && issue_ready;

    // The entry already sitting in the issue register is never re-picked:
    // either it is stalled there, or it is leaving via the handshake.
    always_comb begin
        w_cand = '0;
        for (int i = 0; i < bs; i++) begin
            w_cand[i] = (r_state[i] == WAITING) && independent_instr[i] &&
                        !(r_issue_valid && (r_issue_index == IW'(i)));
        end
    end

    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        w_idx   = '0;
        for (int k = 0; k < bs; k++) begin
            w_idx = r_rr_ptr + IW'(k);
            if (!w_found && w_cand[w_idx]) begin
                w_found = 1'b1;
                w_pick  = w_idx;
            end
        end
    end

    // Alloc and complete are both judged against the pre-edge state, so an
    // alloc to an entry completing in the same cycle is still a violation.
    always_comb begin
        w_err_evt   = 1'b0;
        w_state_nxt = r_state;
        if (w_hs)
            w_state_nxt[r_issue_index] = ISSUED;
        if (alloc_valid) begin
            if (r_state[alloc_index] == FREE) w_state_nxt[alloc_index] = WAITING;
            else                              w_err_evt = 1'b1;
        end
        if (complete_valid) begin
            if (r_state[complete_index] == ISSUED) w_state_nxt[complete_index] = FREE;
            else                                   w_err_evt = 1'b1;
        end
        w_occ_nxt = '0;
        for (int i = 0; i < bs; i++) begin
            if (w_state_nxt[i] != FREE) w_occ_nxt = w_occ_nxt + (IW+1)'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < bs; i++) r_state[i] <= FREE;
            r_issue_valid <= 1'b0;
            r_issue_index <= '0;
            r_rr_ptr      <= '0;
            r_occ         <= '0;
            r_err         <= 1'b0;
        end else if (flush) begin
            for (int i = 0; i < bs; i++) r_state[i] <= FREE;
            r_issue_valid <= 1'b0;
            r_rr_ptr      <= '0;
            r_occ         <= '0;
            r_err         <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_occ   <= w_occ_nxt;
            if (w_err_evt) r_err <= 1'b1;
            if (!r_issue_valid || issue_ready) begin
                r_issue_valid <= w_found;
                if (w_found) r_issue_index <= w_pick;
            end
            if (w_hs) r_rr_ptr <= r_issue_index + IW'(1);
        end
    end

    assign issue_valid = r_issue_valid;
    assign issue_index = r_issue_index;
    assign occupancy   = r_occ;
    assign full        = (r_occ == (IW+1)'(bs));
    assign empty       = (r_occ == '0);
    assign err         = r_err;

endmodule

// File: tb/tb_esm_issue_scheduler.sv
// Bench for esm_issue_scheduler: vector table for the basic issue flow, hand
// sequences for round-robin, stall, full, error and reset corners.
module tb_esm_issue_scheduler;
    localparam int BS = 16;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            flush = 1'b0;
    logic            alloc_valid = 1'b0;
    logic [3:0]      alloc_index = '0;
    logic [0:BS-1]   indep = '0;
    logic            issue_valid;
    logic [3:0]      issue_index;
    logic            issue_ready = 1'b0;
    logic            complete_valid = 1'b0;
    logic [3:0]      complete_index = '0;
    logic [4:0]      occupancy;
    logic            full;
    logic            empty;
    logic            err;

    int errors = 0;
    int checks = 0;
    int sb_q[$];

    typedef struct {
        int av; int ai; int cv; int ci;
        int ev; int ei; int eocc; int eerr;
    } vec_t;
    vec_t tbl[8];

    esm_issue_scheduler #(.bs(BS)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .alloc_valid(alloc_valid), .alloc_index(alloc_index),
        .independent_instr(indep),
        .issue_valid(issue_valid), .issue_index(issue_index), .issue_ready(issue_ready),
        .complete_valid(complete_valid), .complete_index(complete_index),
        .occupancy(occupancy), .full(full), .empty(empty), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic chk_out(input string nm, input int v, input int idx, input int occ, input int e);
        chk({nm, "_valid"}, int'(issue_valid), v);
        if (v != 0) chk({nm, "_index"}, int'(issue_index), idx);
        chk({nm, "_occ"}, int'(occupancy), occ);
        chk({nm, "_full"}, int'(full), (occ == BS) ? 1 : 0);
        chk({nm, "_empty"}, int'(empty), (occ == 0) ? 1 : 0);
        chk({nm, "_err"}, int'(err), e);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
        alloc_valid    = 1'b0;
        complete_valid = 1'b0;
        flush          = 1'b0;
    endtask

    task automatic do_alloc(input int i);
        alloc_valid = 1'b1; alloc_index = 4'(i); cyc();
    endtask

    task automatic do_cmpl(input int i);
        complete_valid = 1'b1; complete_index = 4'(i); cyc();
    endtask

    task automatic do_flush();
        flush = 1'b1; cyc();
    endtask

    // Scoreboard: every handshake the next edge will take must match the
    // oldest expected issue index.
    always @(negedge clk) begin : mon
        int e;
        if (!rst && !flush && issue_valid && issue_ready) begin
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected: got issue %0d expected none", issue_index);
            end else begin
                e = sb_q.pop_front();
                if (int'(issue_index) != e) begin
                    errors++;
                    $display("FAIL sb_order: got issue %0d expected %0d", issue_index, e);
                end
            end
        end
    end

    initial begin
        // Basic flow: alloc 0,1,2 then drain and complete.
        tbl[0] = '{1, 0, 0, 0, 0, 0, 1, 0};
        tbl[1] = '{1, 1, 0, 0, 1, 0, 2, 0};
        tbl[2] = '{1, 2, 0, 0, 1, 1, 3, 0};
        tbl[3] = '{0, 0, 0, 0, 1, 2, 3, 0};
        tbl[4] = '{0, 0, 0, 0, 0, 0, 3, 0};
        tbl[5] = '{0, 0, 1, 0, 0, 0, 2, 0};
        tbl[6] = '{0, 0, 1, 1, 0, 0, 1, 0};
        tbl[7] = '{0, 0, 1, 2, 0, 0, 0, 0};

        repeat (2) @(posedge clk);
        #1;
        chk_out("reset", 0, 0, 0, 0);
        chk("reset_index", int'(issue_index), 0);
        rst = 1'b0;

        indep = '1;
        issue_ready = 1'b1;
        sb_q.push_back(0); sb_q.push_back(1); sb_q.push_back(2);
        for (int i = 0; i < 8; i++) begin
            alloc_valid    = tbl[i].av[0];
            alloc_index    = 4'(tbl[i].ai);
            complete_valid = tbl[i].cv[0];
            complete_index = 4'(tbl[i].ci);
            cyc();
            chk_out($sformatf("vec%0d", i), tbl[i].ev, tbl[i].ei, tbl[i].eocc, tbl[i].eerr);
        end

        // Round-robin: bring rr_ptr to 4, then 5 before 3; then rr_ptr 6, 15 before 0.
        do_flush();
        chk_out("rr_flush", 0, 0, 0, 0);
        sb_q.push_back(3); sb_q.push_back(5); sb_q.push_back(3);
        sb_q.push_back(5); sb_q.push_back(15); sb_q.push_back(0);
        do_alloc(3);
        cyc();
        chk_out("rr_pick3", 1, 3, 1, 0);
        cyc();
        do_cmpl(3);
        indep = '0;
        do_alloc(3);
        do_alloc(5);
        chk_out("rr_nocand", 0, 0, 2, 0);
        indep[3] = 1'b1; indep[5] = 1'b1;
        cyc();
        chk_out("rr_first5", 1, 5, 2, 0);
        cyc();
        chk_out("rr_then3", 1, 3, 2, 0);
        cyc();
        do_cmpl(3);
        do_cmpl(5);
        do_alloc(5);
        cyc();
        cyc();
        do_cmpl(5);
        indep = '0;
        do_alloc(0);
        do_alloc(15);
        indep[0] = 1'b1; indep[15] = 1'b1;
        cyc();
        chk_out("rr_first15", 1, 15, 2, 0);
        cyc();
        chk_out("rr_then0", 1, 0, 2, 0);
        cyc();
        do_cmpl(15);
        do_cmpl(0);
        chk_out("rr_done", 0, 0, 0, 0);

        // Stall: 7 held stable while ready is low, even after its bit drops.
        do_flush();
        issue_ready = 1'b0;
        indep = '1;
        sb_q.push_back(7); sb_q.push_back(8);
        do_alloc(7);
        cyc();
        indep[7] = 1'b0;
        do_alloc(8);
        chk_out("stall0", 1, 7, 2, 0);
        cyc();
        chk_out("stall1", 1, 7, 2, 0);
        cyc();
        chk_out("stall2", 1, 7, 2, 0);
        issue_ready = 1'b1;
        cyc();
        chk_out("stall_release", 1, 8, 2, 0);
        issue_ready = 1'b0;
        do_cmpl(7);
        chk_out("stall_cmpl7", 1, 8, 1, 0);
        issue_ready = 1'b1;
        cyc();
        chk_out("stall_done", 0, 0, 1, 0);

        // Full buffer, free one, re-alloc it the next cycle.
        do_flush();
        indep = '0;
        sb_q.push_back(4);
        for (int i = 0; i < BS; i++) do_alloc(i);
        chk_out("full_all", 0, 0, 16, 0);
        indep[4] = 1'b1;
        cyc();
        chk_out("full_pick4", 1, 4, 16, 0);
        cyc();
        indep = '0;
        chk_out("full_issued4", 0, 0, 16, 0);
        do_cmpl(4);
        chk_out("full_cmpl4", 0, 0, 15, 0);
        do_alloc(4);
        chk_out("full_realloc4", 0, 0, 16, 0);

        // Protocol errors are sticky until flush.
        do_flush();
        indep = '0;
        do_alloc(9);
        do_cmpl(9);
        chk_out("err_cmpl_waiting", 0, 0, 1, 1);
        cyc();
        cyc();
        chk_out("err_sticky", 0, 0, 1, 1);
        issue_ready = 1'b0;
        indep[9] = 1'b1;
        cyc();
        chk_out("err_issue9", 1, 9, 1, 1);
        do_flush();
        chk_out("err_flush", 0, 0, 0, 0);

        // Same-index alloc + complete: complete wins, alloc flagged.
        issue_ready = 1'b1;
        indep = '0;
        sb_q.push_back(2);
        do_alloc(2);
        indep[2] = 1'b1;
        cyc();
        chk_out("same_pick2", 1, 2, 1, 0);
        cyc();
        indep = '0;
        alloc_valid = 1'b1; alloc_index = 4'd2;
        complete_valid = 1'b1; complete_index = 4'd2;
        cyc();
        chk_out("same_idx", 0, 0, 0, 1);
        do_flush();

        // Asynchronous reset while an issue is pending.
        issue_ready = 1'b0;
        indep = '1;
        do_alloc(1);
        do_alloc(2);
        chk_out("arst_pre", 1, 1, 2, 0);
        #3 rst = 1'b1;
        #1;
        chk_out("arst_mid", 0, 0, 0, 0);
        chk("arst_index", int'(issue_index), 0);
        cyc();
        #2 rst = 1'b0;
        issue_ready = 1'b1;
        cyc();
        cyc();
        chk_out("arst_free", 0, 0, 0, 0);
        sb_q.push_back(1);
        do_alloc(1);
        chk_out("arst_realloc", 0, 0, 1, 0);
        cyc();
        chk_out("arst_pick1", 1, 1, 1, 0);
        cyc();
        cyc();
        chk("sb_left", sb_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
